// File: rtl/rocket_pkg.sv
// Shared types and constants for the rocket movement controller.
package rocket_pkg;

    localparam int COORD_W         = 32'sd11;
    localparam int DEF_SPEED       = 32'sd4;
    localparam int DEF_ROCKET_SIZE = 32'sd8;
    localparam int TIMER_W         = 32'sd8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_EXPLODE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } rocket_state_t;

    // True when a rocket top-left corner keeps the whole bracket on screen.
    // x_max/y_max are the largest legal top-left coordinates.
    function automatic logic in_bounds(input logic signed [11:0] x,
                                       input logic signed [11:0] y,
                                       input logic signed [11:0] x_max,
                                       input logic signed [11:0] y_max);
        return (x >= 12'sd0) && (y >= 12'sd0) && (x <= x_max) && (y <= y_max);
    endfunction

endpackage

// File: rtl/rocket_move_ctrl_frame_timer.sv
// Loadable per-frame down-counter; shared by the explosion and cooldown phases.
// done is high whenever the count has reached zero.
module rocket_frame_timer
    import rocket_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_r;

    // Load has priority; otherwise count down once per frame tick, saturating at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (tick && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/rocket_move_ctrl.sv
// Rocket (projectile) position controller for Battle City.
// Spawns the rocket at the tank muzzle on a frame boundary after a fire
// request, advances it SPEED px per frame, and ends the flight on a hit or
// at the screen edge, followed by a re-fire cooldown.
// Build option: define ROCKET_EXPLODE_EN to insert an explosion phase
// (explodeActive) between a hit and the cooldown.
module rocket_move_ctrl
    import rocket_pkg::*;
#(
    parameter int SPEED           = DEF_SPEED,
    parameter int ROCKET_SIZE     = DEF_ROCKET_SIZE,
    parameter int TANK_SIZE       = 32'sd32,
    parameter int SCREEN_W        = 32'sd640,
    parameter int SCREEN_H        = 32'sd480,
    parameter int COOLDOWN_FRAMES = 32'sd16
`ifdef ROCKET_EXPLODE_EN
    ,
    parameter int EXPLODE_FRAMES  = 32'sd8
`endif
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               fireReq,
    input  logic [COORD_W-1:0] tankTopLeftX,
    input  logic [COORD_W-1:0] tankTopLeftY,
    input  logic [1:0]         tankDir,
    input  logic               collision,
    output logic [COORD_W-1:0] topLeftX,
    output logic [COORD_W-1:0] topLeftY,
    output logic               rocketActive,
    output logic               explodeActive
);

    // Geometry in signed 12-bit so spawn/move results below zero are visible.
    localparam logic signed [11:0] SPD_S   = 12'(SPEED);
    localparam logic signed [11:0] RS_S    = 12'(ROCKET_SIZE);
    localparam logic signed [11:0] TS_S    = 12'(TANK_SIZE);
    localparam logic signed [11:0] CO_S    = 12'((TANK_SIZE - ROCKET_SIZE) / 2);
    localparam logic signed [11:0] X_MAX_S = 12'(SCREEN_W - ROCKET_SIZE);
    localparam logic signed [11:0] Y_MAX_S = 12'(SCREEN_H - ROCKET_SIZE);
    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN_FRAMES - 1);
`ifdef ROCKET_EXPLODE_EN
    localparam logic [TIMER_W-1:0] BOOM_LOAD = TIMER_W'(EXPLODE_FRAMES - 1);
`endif

    rocket_state_t      state_r, state_nxt;
    dir_t               dir_r, dir_nxt;
    logic [COORD_W-1:0] pos_x_r, pos_x_nxt;
    logic [COORD_W-1:0] pos_y_r, pos_y_nxt;
    logic               fire_pend_r, fire_pend_nxt;
    logic               hit_r, hit_nxt;
    logic               active_r;

    logic signed [11:0] tank_x_s, tank_y_s, cur_x_s, cur_y_s;
    logic signed [11:0] spawn_x_s, spawn_y_s, move_x_s, move_y_s;
    logic               spawn_ok_s, move_ok_s, hit_now_s;
    logic               tmr_load_s, tmr_tick_s, tmr_done_s;
    logic [TIMER_W-1:0] tmr_val_s;

    rocket_frame_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .load       (tmr_load_s),
        .load_value (tmr_val_s),
        .tick       (tmr_tick_s),
        .done       (tmr_done_s)
    );

    // Candidate muzzle spawn point and next in-flight position, with bound checks.
    always_comb begin
        tank_x_s = $signed({1'b0, tankTopLeftX});
        tank_y_s = $signed({1'b0, tankTopLeftY});
        cur_x_s  = $signed({1'b0, pos_x_r});
        cur_y_s  = $signed({1'b0, pos_y_r});
        case (dir_t'(tankDir))
            DIR_UP:    begin spawn_x_s = tank_x_s + CO_S; spawn_y_s = tank_y_s - RS_S; end
            DIR_RIGHT: begin spawn_x_s = tank_x_s + TS_S; spawn_y_s = tank_y_s + CO_S; end
            DIR_DOWN:  begin spawn_x_s = tank_x_s + CO_S; spawn_y_s = tank_y_s + TS_S; end
            DIR_LEFT:  begin spawn_x_s = tank_x_s - RS_S; spawn_y_s = tank_y_s + CO_S; end
            default:   begin spawn_x_s = tank_x_s;        spawn_y_s = tank_y_s;        end
        endcase
        case (dir_r)
            DIR_UP:    begin move_x_s = cur_x_s;         move_y_s = cur_y_s - SPD_S; end
            DIR_RIGHT: begin move_x_s = cur_x_s + SPD_S; move_y_s = cur_y_s;         end
            DIR_DOWN:  begin move_x_s = cur_x_s;         move_y_s = cur_y_s + SPD_S; end
            DIR_LEFT:  begin move_x_s = cur_x_s - SPD_S; move_y_s = cur_y_s;         end
            default:   begin move_x_s = cur_x_s;         move_y_s = cur_y_s;         end
        endcase
        spawn_ok_s = in_bounds(spawn_x_s, spawn_y_s, X_MAX_S, Y_MAX_S);
        move_ok_s  = in_bounds(move_x_s, move_y_s, X_MAX_S, Y_MAX_S);
        hit_now_s  = hit_r | collision;
    end

    // Next-state logic; all decisions are taken on frame boundaries only.
    always_comb begin
        state_nxt     = state_r;
        dir_nxt       = dir_r;
        pos_x_nxt     = pos_x_r;
        pos_y_nxt     = pos_y_r;
        fire_pend_nxt = fire_pend_r;
        hit_nxt       = hit_r;
        tmr_load_s    = 1'b0;
        tmr_val_s     = {TIMER_W{1'b0}};
        tmr_tick_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hit_nxt = 1'b0;
                if (fireReq) begin
                    fire_pend_nxt = 1'b1;
                end else begin
                    fire_pend_nxt = fire_pend_r;
                end
                if (startOfFrame && fire_pend_r) begin
                    fire_pend_nxt = 1'b0;
                    dir_nxt       = dir_t'(tankDir);
                    if (spawn_ok_s) begin
                        pos_x_nxt = spawn_x_s[COORD_W-1:0];
                        pos_y_nxt = spawn_y_s[COORD_W-1:0];
                        state_nxt = ST_FLYING;
                    end else begin
                        state_nxt  = ST_COOLDOWN;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = COOL_LOAD;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLYING: begin
                fire_pend_nxt = 1'b0;
                if (collision) begin
                    hit_nxt = 1'b1;
                end else begin
                    hit_nxt = hit_r;
                end
                if (startOfFrame) begin
                    if (hit_now_s) begin
                        hit_nxt    = 1'b0;
                        tmr_load_s = 1'b1;
`ifdef ROCKET_EXPLODE_EN
                        state_nxt  = ST_EXPLODE;
                        tmr_val_s  = BOOM_LOAD;
`else
                        state_nxt  = ST_COOLDOWN;
                        tmr_val_s  = COOL_LOAD;
`endif
                    end else if (move_ok_s) begin
                        pos_x_nxt = move_x_s[COORD_W-1:0];
                        pos_y_nxt = move_y_s[COORD_W-1:0];
                    end else begin
                        hit_nxt    = 1'b0;
                        state_nxt  = ST_COOLDOWN;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = COOL_LOAD;
                    end
                end else begin
                    state_nxt = ST_FLYING;
                end
            end
`ifdef ROCKET_EXPLODE_EN
            ST_EXPLODE: begin
                fire_pend_nxt = 1'b0;
                hit_nxt       = 1'b0;
                tmr_tick_s    = startOfFrame;
                if (startOfFrame && tmr_done_s) begin
                    state_nxt  = ST_COOLDOWN;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = COOL_LOAD;
                end else begin
                    state_nxt = ST_EXPLODE;
                end
            end
`endif
            ST_COOLDOWN: begin
                fire_pend_nxt = 1'b0;
                hit_nxt       = 1'b0;
                tmr_tick_s    = startOfFrame;
                if (startOfFrame && tmr_done_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_COOLDOWN;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                fire_pend_nxt = 1'b0;
                hit_nxt       = 1'b0;
            end
        endcase
    end

    // State, position and status flags; status registered alongside the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_IDLE;
            dir_r       <= DIR_UP;
            pos_x_r     <= {COORD_W{1'b0}};
            pos_y_r     <= {COORD_W{1'b0}};
            fire_pend_r <= 1'b0;
            hit_r       <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            dir_r       <= dir_nxt;
            pos_x_r     <= pos_x_nxt;
            pos_y_r     <= pos_y_nxt;
            fire_pend_r <= fire_pend_nxt;
            hit_r       <= hit_nxt;
            active_r    <= (state_nxt == ST_FLYING);
        end
    end

`ifdef ROCKET_EXPLODE_EN
    logic explode_r;

    // Explosion flag registered alongside the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            explode_r <= 1'b0;
        end else begin
            explode_r <= (state_nxt == ST_EXPLODE);
        end
    end

    assign explodeActive = explode_r;
`else
    assign explodeActive = 1'b0;
`endif

    assign topLeftX     = pos_x_r;
    assign topLeftY     = pos_y_r;
    assign rocketActive = active_r;

endmodule

// File: tb/tb_rocket_move_ctrl.sv
// Self-checking bench for rocket_move_ctrl: a frame-level model of the rocket
// life cycle is compared against the DUT on every cycle, and directed
// scenarios pin key positions and flags with literal expectations.
module tb_rocket_move_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_FLY  = 1;
    localparam int PH_BOOM = 2;
    localparam int PH_COOL = 3;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        fireReq = 1'b0;
    logic [10:0] tankTopLeftX = 11'd0;
    logic [10:0] tankTopLeftY = 11'd0;
    logic [1:0]  tankDir = 2'd0;
    logic        collision = 1'b0;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        rocketActive;
    logic        explodeActive;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit cmp_en   = 1'b0;

    // model state: phase, rocket position, direction, frames left, latches
    int m_phase = PH_IDLE;
    int m_x = 0, m_y = 0, m_left = 0;
    logic [1:0] m_dir = 2'd0;
    bit m_pend = 1'b0, m_hit = 1'b0;

    rocket_move_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .fireReq       (fireReq),
        .tankTopLeftX  (tankTopLeftX),
        .tankTopLeftY  (tankTopLeftY),
        .tankDir       (tankDir),
        .collision     (collision),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .rocketActive  (rocketActive),
        .explodeActive (explodeActive)
    );

    always #5 clk = ~clk;

    function automatic int dx(input logic [1:0] d);
        return (d == 2'd1) ? 1 : ((d == 2'd3) ? -1 : 0);
    endfunction
    function automatic int dy(input logic [1:0] d);
        return (d == 2'd2) ? 1 : ((d == 2'd0) ? -1 : 0);
    endfunction
    // rocket centred on the tank centre, pushed out by half tank + half rocket
    function automatic int spawn_x(input int tx, input logic [1:0] d);
        return tx + 16 - 4 + 20 * dx(d);
    endfunction
    function automatic int spawn_y(input int ty, input logic [1:0] d);
        return ty + 16 - 4 + 20 * dy(d);
    endfunction
    function automatic bit on_screen(input int x, input int y);
        return (x >= 0) && (y >= 0) && (x + 8 <= 640) && (y + 8 <= 480);
    endfunction

    // frame-level model of the rocket life cycle
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase <= PH_IDLE; m_x <= 0; m_y <= 0; m_left <= 0;
            m_dir <= 2'd0; m_pend <= 1'b0; m_hit <= 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (fireReq) m_pend <= 1'b1;
                    if (startOfFrame && m_pend) begin
                        m_pend <= 1'b0;
                        m_dir  <= tankDir;
                        if (on_screen(spawn_x(int'(tankTopLeftX), tankDir),
                                      spawn_y(int'(tankTopLeftY), tankDir))) begin
                            m_x <= spawn_x(int'(tankTopLeftX), tankDir);
                            m_y <= spawn_y(int'(tankTopLeftY), tankDir);
                            m_phase <= PH_FLY;
                        end else begin
                            m_phase <= PH_COOL; m_left <= 16;
                        end
                    end
                end
                PH_FLY: begin
                    if (collision) m_hit <= 1'b1;
                    if (startOfFrame) begin
                        if (m_hit || collision) begin
                            m_hit <= 1'b0;
`ifdef ROCKET_EXPLODE_EN
                            m_phase <= PH_BOOM; m_left <= 8;
`else
                            m_phase <= PH_COOL; m_left <= 16;
`endif
                        end else if (on_screen(m_x + 4 * dx(m_dir), m_y + 4 * dy(m_dir))) begin
                            m_x <= m_x + 4 * dx(m_dir);
                            m_y <= m_y + 4 * dy(m_dir);
                        end else begin
                            m_hit <= 1'b0; m_phase <= PH_COOL; m_left <= 16;
                        end
                    end
                end
                PH_BOOM: begin
                    if (startOfFrame) begin
                        if (m_left == 1) begin m_phase <= PH_COOL; m_left <= 16; end
                        else m_left <= m_left - 1;
                    end
                end
                PH_COOL: begin
                    if (startOfFrame) begin
                        if (m_left == 1) m_phase <= PH_IDLE;
                        else m_left <= m_left - 1;
                    end
                end
                default: m_phase <= PH_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt = chk_cnt + 1;
        if (act == exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_x", int'(topLeftX), m_x);
            check("model_y", int'(topLeftY), m_y);
            check("model_active", int'(rocketActive), (m_phase == PH_FLY) ? 1 : 0);
            check("model_explode", int'(explodeActive), (m_phase == PH_BOOM) ? 1 : 0);
        end
    end

    // one clock with the given inputs, returning 1 ns after the active edge
    task automatic cyc(input bit sof, input bit fire, input bit coll);
        @(negedge clk);
        #1;
        startOfFrame = sof; fireReq = fire; collision = coll;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0; fireReq = 1'b0; collision = 1'b0;
    endtask

    task automatic frame();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic set_tank(input int x, input int y, input int d);
        tankTopLeftX = 11'(x); tankTopLeftY = 11'(y); tankDir = 2'(d);
    endtask

    initial begin
        #2 resetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 resetN = 1'b1;
        cmp_en = 1'b1;
        check("reset_x", int'(topLeftX), 0);
        check("reset_active", int'(rocketActive), 0);

        // UP from (100,200)
        set_tank(100, 200, 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("up_spawn_x", int'(topLeftX), 112);
        check("up_spawn_y", int'(topLeftY), 192);
        check("up_active", int'(rocketActive), 1);
        frame();
        check("up_move_y", int'(topLeftY), 188);
        cyc(1'b0, 1'b0, 1'b1);          // collision latched between frames
        frame();
        check("hit_active", int'(rocketActive), 0);
`ifdef ROCKET_EXPLODE_EN
        check("hit_explode", int'(explodeActive), 1);
        frames(8);
`else
        check("hit_explode", int'(explodeActive), 0);
`endif
        frames(16);

        // RIGHT from (600,100): spawn at edge, then leaves screen
        set_tank(600, 100, 1);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("right_spawn_x", int'(topLeftX), 632);
        check("right_spawn_y", int'(topLeftY), 112);
        frame();
        check("edge_active", int'(rocketActive), 0);
        check("edge_hold_x", int'(topLeftX), 632);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            frame();
        end
        check("cool15_active", int'(rocketActive), 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();                        // 16th frame: back to idle, fire dropped
        check("cool16_active", int'(rocketActive), 0);
        frame();
        check("no_queue_active", int'(rocketActive), 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("refire_active", int'(rocketActive), 1);
        frame();
        frames(16);

        // DOWN spawn at (300,240), collision coincident with frame start
        set_tank(288, 208, 2);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("down_spawn_y", int'(topLeftY), 240);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("boom_x", int'(topLeftX), 300);
        check("boom_y", int'(topLeftY), 240);
        check("boom_active", int'(rocketActive), 0);
`ifdef ROCKET_EXPLODE_EN
        frames(7);
        check("boom7_explode", int'(explodeActive), 1);
        frame();
        check("boom8_explode", int'(explodeActive), 0);
`else
        check("noboom_explode", int'(explodeActive), 0);
`endif
        frames(16);

        // UP from (100,4): spawn off screen, straight to cooldown
        set_tank(100, 4, 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("offscr_active", int'(rocketActive), 0);
        check("offscr_hold_x", int'(topLeftX), 300);
        frames(16);

        // LEFT from (300,300); later direction change ignored
        set_tank(300, 300, 3);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("left_spawn_x", int'(topLeftX), 292);
        check("left_spawn_y", int'(topLeftY), 312);
        tankDir = 2'd0;
        frame();
        check("left_move_x", int'(topLeftX), 288);
        check("left_move_y", int'(topLeftY), 312);
        cyc(1'b0, 1'b0, 1'b1);
        frame();
`ifdef ROCKET_EXPLODE_EN
        frames(8);
`endif
        frames(16);

        // asynchronous reset while flying at (400,50)
        set_tank(388, 58, 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("pre_rst_x", int'(topLeftX), 400);
        check("pre_rst_y", int'(topLeftY), 50);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("rst_x", int'(topLeftX), 0);
        check("rst_y", int'(topLeftY), 0);
        check("rst_active", int'(rocketActive), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 resetN = 1'b1;
        frame();
        check("post_rst_active", int'(rocketActive), 0);
        cyc(1'b0, 1'b1, 1'b0);
        frame();
        check("post_rst_fire_y", int'(topLeftY), 50);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
